muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; only 32 is supported.
REQ-002 SHALL have port: clock  in  1  rising-edge clock.
REQ-003 SHALL have port: clear  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port: op  in  2  00 MUL (signed), 01 DIV (signed), 10/11 reserved.
REQ-006 SHALL have port: RA  in  32  multiplicand / dividend.
REQ-007 SHALL have port: RB  in  32  multiplier / divisor.
REQ-008 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-009 SHALL have port: done  out  1  single-cycle completion pulse.
REQ-010 SHALL have port: hi  out  32  MUL: product[63:32]; DIV: remainder.
REQ-011 SHALL have port: lo  out  32  MUL: product[31:0]; DIV: quotient.
REQ-012 SHALL have port: div_by_zero  out  1  status of the last completed DIV; held until the next done.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, FIX and DONE; DONE always returns to IDLE on the next edge.
REQ-014 SHALL accept when start=1 in IDLE (cycle 0), latching op, RA and RB; inputs after cycle 0 SHALL be ignored.
REQ-015 SHALL ignore start while busy=1; no queueing.
REQ-016 MUL SHALL run radix-4 Booth, 2 multiplier bits per cycle, for 16 cycles (cycles 1-16), with DONE in cycle 17.
REQ-017 MUL SHALL sign-extend the multiplicand to 64 bits and produce the exact 64-bit two's-complement product.
REQ-018 DIV SHALL run signed restoring division on magnitudes, 1 bit per cycle, for 32 cycles (1-32), then apply sign correction in FIX (cycle 33), with DONE in cycle 34.
REQ-019 DIV quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-020 DIV with RB=0 SHALL skip iteration and go to DONE in cycle 1: hi=RA, lo=32'hFFFFFFFF, div_by_zero=1.
REQ-021 DIV 0x80000000 / -1 SHALL yield lo=0x80000000 and hi=0 (wrap), with div_by_zero=0.
REQ-022 A reserved op SHALL reach DONE in cycle 1 with hi, lo and div_by_zero unchanged.
REQ-023 hi, lo and div_by_zero SHALL update only on the edge entering DONE and hold otherwise.
REQ-024 done SHALL be high exactly during the DONE cycle; busy SHALL also be high during DONE.
REQ-025 start=1 during the DONE cycle SHALL be ignored; the earliest re-acceptance is the following IDLE cycle.

Reset
REQ-026 clear=1 SHALL immediately force IDLE with busy=0, done=0, hi=0, lo=0, div_by_zero=0 and the iteration counter at 0.
REQ-027 clear asserted mid-operation SHALL abort the operation with no done pulse; the first post-reset start SHALL behave as from power-up.

Configuration
REQ-028 SHALL support macro MULDIV_SEQ_DIV_EN: when defined, DIV, FIX and the divide datapath are present.
REQ-029 Without MULDIV_SEQ_DIV_EN, op=01 SHALL behave as reserved (REQ-022), and div_by_zero SHALL be tied to 0.

Structure
REQ-030 SHALL place in shared package muldiv_pkg: the op encodings, the state enum, and the constants MUL_ITERS=16 and DIV_ITERS=32.
REQ-031 SHALL instantiate one sub-module, booth_r4_step: a combinational stage that takes 3 multiplier bits and the multiplicand and returns the signed partial product (0, +/-M, +/-2M).

Verification
REQ-032 SHALL verify MUL RA=7, RB=-3 -> done in cycle 17, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-033 SHALL verify MUL RA=RB=0x80000000 -> hi=40000000, lo=00000000; and a start asserted in cycle 5 is ignored (same result, single done).
REQ-034 SHALL verify DIV RA=-7, RB=2 -> done in cycle 34, lo=FFFFFFFD, hi=FFFFFFFF, div_by_zero=0.
REQ-035 SHALL verify DIV RA=5, RB=0 -> done in cycle 1, hi=00000005, lo=FFFFFFFF, div_by_zero=1; and without the macro the same stimulus gives done in cycle 1 with hi/lo unchanged.
REQ-036 SHALL verify clear pulsed in cycle 8 of a MUL -> busy=0 and hi=lo=0 immediately, no done, and the next MUL 3*4 gives lo=0000000C in cycle 17.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit: op codes, FSM states,
// iteration counts and a conditional-negate helper.
package muldiv_pkg;

  localparam int MUL_ITERS = 16;
  localparam int DIV_ITERS = 32;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_booth.sv
// Radix-4 Booth recoding stage: maps three multiplier bits onto a signed partial
// product of 0, +/-M or +/-2M.
module booth_r4_step #(
  parameter int W = 64
) (
  input  logic [2:0]   i_bits,
  input  logic [W-1:0] i_mcand,
  output logic [W-1:0] o_pp
);

  // Booth digit selection
  always_comb begin
    o_pp = {W{1'b0}};
    case (i_bits)
      3'b001, 3'b010: o_pp = i_mcand;
      3'b011:         o_pp = i_mcand << 1;
      3'b100:         o_pp = ~(i_mcand << 1) + {{(W-1){1'b0}}, 1'b1};
      3'b101, 3'b110: o_pp = ~i_mcand + {{(W-1){1'b0}}, 1'b1};
      default:        o_pp = {W{1'b0}};
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential signed multiplier (radix-4 Booth) and optional restoring divider.
// The divider is built only when MULDIV_SEQ_DIV_EN is defined; otherwise op=01 is reserved.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] RA,
  input  logic [WIDTH-1:0] RB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_mcand;
  logic [32:0] r_mplr;
  logic [63:0] r_acc;
  logic [63:0] w_pp;
  logic [63:0] w_acc_nxt;

  booth_r4_step #(.W(64)) u_booth (
    .i_bits  (r_mplr[2:0]),
    .i_mcand (r_mcand),
    .o_pp    (w_pp)
  );

  assign w_acc_nxt = r_acc + w_pp;

`ifdef MULDIV_SEQ_DIV_EN
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvsr;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dbz;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_qbit;

  // Partial remainder stays below the divisor, so 33 bits hold the trial subtraction.
  assign w_rem_sh    = {r_rem, r_quo[31]};
  assign w_diff      = w_rem_sh - {1'b0, r_dvsr};
  assign w_qbit      = ~w_diff[32];
  assign div_by_zero = r_dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Control FSM and datapath; results are written only on the edge entering DONE
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= 6'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_mcand <= 64'd0;
      r_mplr  <= 33'd0;
      r_acc   <= 64'd0;
`ifdef MULDIV_SEQ_DIV_EN
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_dvsr  <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= 6'd0;
            if (op == OP_MUL) begin
              r_mcand <= {{32{RA[31]}}, RA};
              r_mplr  <= {RB, 1'b0};
              r_acc   <= 64'd0;
              r_state <= ST_MUL;
`ifdef MULDIV_SEQ_DIV_EN
            end else if ((op == OP_DIV) && (RB == 32'd0)) begin
              r_hi    <= RA;
              r_lo    <= 32'hFFFF_FFFF;
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else if (op == OP_DIV) begin
              r_rem   <= 32'd0;
              r_quo   <= cond_neg(RA, RA[31]);
              r_dvsr  <= cond_neg(RB, RB[31]);
              r_neg_q <= RA[31] ^ RB[31];
              r_neg_r <= RA[31];
              r_state <= ST_DIV;
`endif
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          r_acc   <= w_acc_nxt;
          r_mcand <= r_mcand << 2;
          r_mplr  <= {{2{r_mplr[32]}}, r_mplr[32:2]};
          if (r_cnt == 6'(MUL_ITERS - 1)) begin
            r_hi    <= w_acc_nxt[63:32];
            r_lo    <= w_acc_nxt[31:0];
            r_cnt   <= 6'd0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
`ifdef MULDIV_SEQ_DIV_EN
        ST_DIV: begin
          r_rem <= w_qbit ? w_diff[31:0] : w_rem_sh[31:0];
          r_quo <= {r_quo[30:0], w_qbit};
          if (r_cnt == 6'(DIV_ITERS - 1)) begin
            r_cnt   <= 6'd0;
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        ST_FIX: begin
          r_lo    <= cond_neg(r_quo, r_neg_q);
          r_hi    <= cond_neg(r_rem, r_neg_r);
          r_dbz   <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= 6'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against an arithmetic reference model.
// Expectations follow MULDIV_SEQ_DIV_EN: without it, DIV is treated as a reserved op.
module tb_muldiv_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [1:0]  op;
  logic [31:0] RA;
  logic [31:0] RB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  logic        m_dbz = 1'b0;

  always #5 clock = ~clock;

  muldiv_seq #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .op          (op),
    .RA          (RA),
    .RB          (RB),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic, returns the cycle in which done is expected
  task automatic model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int ecyc);
    longint p;
    int     sa;
    int     sb;
    bit     div_en;
`ifdef MULDIV_SEQ_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    sa = a;
    sb = b;
    if (o == 2'b00) begin
      p     = longint'(sa) * longint'(sb);
      m_hi  = p[63:32];
      m_lo  = p[31:0];
      ecyc  = 17;
    end else if (o == 2'b01 && div_en) begin
      if (b == 32'd0) begin
        m_hi  = a;
        m_lo  = 32'hFFFF_FFFF;
        m_dbz = 1'b1;
        ecyc  = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        m_hi  = 32'd0;
        m_lo  = 32'h8000_0000;
        m_dbz = 1'b0;
        ecyc  = 34;
      end else begin
        m_lo  = sa / sb;
        m_hi  = sa % sb;
        m_dbz = 1'b0;
        ecyc  = 34;
      end
    end else begin
      ecyc = 1;
    end
  endtask

  // One operation: start in cycle 0, optional extra start in cycle inj, random noise on inputs
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int inj);
    int ecyc;
    int done_cyc;
    int ndone;
    int nbusy;
    model_op(o, a, b, ecyc);
    @(negedge clock);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    op = o; RA = a; RB = b; start = 1'b1;
    done_cyc = -1; ndone = 0; nbusy = 0;
    for (int c = 1; c <= ecyc; c++) begin
      @(negedge clock);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy) nbusy++;
      start = (c == inj);
      op = 2'($urandom);
      RA = $urandom;
      RB = $urandom;
    end
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(ecyc));
    check({tag, "_done_count"}, 64'(ndone), 64'd1);
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'(ecyc));
    check({tag, "_hi"}, 64'(hi), 64'(m_hi));
    check({tag, "_lo"}, 64'(lo), 64'(m_lo));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(m_dbz));
    @(negedge clock);
    start = 1'b0;
    check({tag, "_after_busy"}, 64'(busy), 64'd0);
    check({tag, "_after_done"}, 64'(done), 64'd0);
    check({tag, "_after_lo"}, 64'(lo), 64'(m_lo));
  endtask

  initial begin
    int          quiet;
    int          r;
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;

    clear = 1'b1; start = 1'b0; op = 2'b00; RA = 32'd0; RB = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    clear = 1'b0;

    run_op("mul_7x-3", 2'b00, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("mul_min2", 2'b00, 32'h8000_0000, 32'h8000_0000, 5);

    // Abort a MUL in cycle 8 with clear
    @(negedge clock);
    op = 2'b00; RA = 32'd7; RB = 32'd9; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    clear = 1'b1;
    #1;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_hi", 64'(hi), 64'd0);
    check("clr_lo", 64'(lo), 64'd0);
    check("clr_dbz", 64'(div_by_zero), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    quiet = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (done || busy) quiet++;
    end
    check("clr_quiet", 64'(quiet), 64'd0);
    run_op("mul_3x4", 2'b00, 32'd3, 32'd4, 0);

    run_op("div_-7_2", 2'b01, 32'hFFFF_FFF9, 32'd2, 34);
    run_op("div_5_0", 2'b01, 32'd5, 32'd0, 1);
    run_op("div_min_-1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_100_-7", 2'b01, 32'd100, 32'hFFFF_FFF9, 12);
    run_op("rsv_10", 2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    run_op("mul_after_rsv", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 17);
    run_op("rsv_11", 2'b11, 32'd1, 32'd2, 0);

    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (r < 5) begin
        o = 2'b00;
      end else if (r < 9) begin
        o = 2'b01;
        if ($urandom_range(0, 4) == 0) b = 32'd0;
        else if ($urandom_range(0, 2) == 0) b = 32'($signed(8'($urandom)));
      end else begin
        o = 2'(2 + $urandom_range(0, 1));
      end
      run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, $urandom_range(1, 40));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
